// File: rtl/core_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
package core_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StHalted  = 2'd2,
    StError   = 2'd3
  } pctrl_state_e;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_flush;
    logic ex_mem_we;
    logic mem_wb_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t PIPE_CTRL_NOP    = pipe_ctrl_t'(7'b000_0000);
  localparam pipe_ctrl_t PIPE_CTRL_RUN    = pipe_ctrl_t'(7'b110_1010);
  // Whole pipe held; only a bubble drains into WB.
  localparam pipe_ctrl_t PIPE_CTRL_FREEZE = pipe_ctrl_t'(7'b000_0001);

endpackage

// File: rtl/pctrl_hazard_detect.sv
// Combinational load-use hazard compare between the ID operands and the load in EX.
module pctrl_hazard_detect #(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
  input  logic                      id_rs1_used_i,
  input  logic                      id_rs2_used_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
  input  logic                      ex_mem_read_i,
  output logic                      load_use_o
);

  logic rs1_hit, rs2_hit;

  always_comb begin
    rs1_hit    = id_rs1_used_i && (id_rs1_i == ex_rd_i);
    rs2_hit    = id_rs2_used_i && (id_rs2_i == ex_rd_i);
    // x0 is never a real dependency.
    load_use_o = ex_mem_read_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: stalls, flushes, memory wait, halt and watchdog.
// Optional perf counters enabled with PIPE_CTRL_PERF_CNT_EN.
module pipeline_ctrl
  import core_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MEM_TIMEOUT    = 16,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
  input  logic                      id_rs1_used_i,
  input  logic                      id_rs2_used_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
  input  logic                      ex_MemRead_i,
  input  logic                      ex_br_taken_i,
  input  logic                      mem_req_i,
  input  logic                      mem_ready_i,
  input  logic                      halt_i,
  input  logic                      resume_i,
  output logic                      pc_we_o,
  output logic                      if_id_we_o,
  output logic                      if_id_flush_o,
  output logic                      id_ex_we_o,
  output logic                      id_ex_flush_o,
  output logic                      ex_mem_we_o,
  output logic                      mem_wb_flush_o,
  output logic                      halted_o,
  output logic                      err_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o,
  output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

  localparam int unsigned WdW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  pctrl_state_e   state_q, state_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
  logic           load_use;
  logic           mem_wait;
  pipe_ctrl_t     ctrl;

  pctrl_hazard_detect #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_hazard (
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .ex_rd_i       (ex_rd_i),
    .ex_mem_read_i (ex_MemRead_i),
    .load_use_o    (load_use)
  );

  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    err_d    = err_q;
    ctrl     = PIPE_CTRL_RUN;
    mem_wait = mem_req_i && !mem_ready_i;

    if (state_q == StError) begin
      ctrl = PIPE_CTRL_FREEZE;
    end else if (mem_wait) begin
      ctrl = PIPE_CTRL_FREEZE;
      if (wd_q == WdW'(MEM_TIMEOUT - 1)) begin
        state_d = StError;
        err_d   = 1'b1;
        wd_d    = '0;
      end else begin
        state_d = StMemWait;
        wd_d    = wd_q + 1'b1;
      end
    end else if (state_q == StHalted) begin
      ctrl = PIPE_CTRL_FREEZE;
      wd_d = '0;
      if (resume_i) begin
        state_d = StRun;
      end
    end else begin
      // RUN, or the cycle a memory wait completes.
      wd_d    = '0;
      state_d = halt_i ? StHalted : StRun;
      if (ex_br_taken_i) begin
        // Squashed ID instruction must not also stall the front end.
        ctrl.if_id_flush = 1'b1;
        ctrl.id_ex_flush = 1'b1;
      end else if (load_use) begin
        ctrl.pc_we       = 1'b0;
        ctrl.if_id_we    = 1'b0;
        ctrl.id_ex_flush = 1'b1;
      end
    end

    if (!rst_n) begin
      ctrl = PIPE_CTRL_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign pc_we_o        = ctrl.pc_we;
  assign if_id_we_o     = ctrl.if_id_we;
  assign if_id_flush_o  = ctrl.if_id_flush;
  assign id_ex_we_o     = ctrl.id_ex_we;
  assign id_ex_flush_o  = ctrl.id_ex_flush;
  assign ex_mem_we_o    = ctrl.ex_mem_we;
  assign mem_wb_flush_o = ctrl.mem_wb_flush;
  assign halted_o       = rst_n && (state_q == StHalted);
  assign err_o          = err_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((state_q != StError) && !ctrl.pc_we) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      // Only a taken branch raises the IF/ID flush.
      if (ctrl.if_id_flush) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
